// File: rtl/t48_db_bus_ctrl_if.sv
// Bundles the internal data-bus mux port and the external D0-D7/strobe pins of
// the T48 data-bus controller. The slave modport is the controller side.
interface t48_db_bus_ctrl_if;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       write_bus_i;
  logic       read_bus_i;
  logic       orl_i;
  logic       anl_i;
  logic       movx_rd_i;
  logic       movx_wr_i;
  logic [7:0] db_i;
  logic [7:0] db_o;
  logic       db_dir_o;
  logic       ale_o;
  logic       rd_n_o;
  logic       wr_n_o;
  logic       busy_o;

  modport slave (
    input  data_i, write_bus_i, read_bus_i, orl_i, anl_i, movx_rd_i, movx_wr_i, db_i,
    output data_o, db_o, db_dir_o, ale_o, rd_n_o, wr_n_o, busy_o
  );

  modport master (
    output data_i, write_bus_i, read_bus_i, orl_i, anl_i, movx_rd_i, movx_wr_i, db_i,
    input  data_o, db_o, db_dir_o, ale_o, rd_n_o, wr_n_o, busy_o
  );
endinterface

// File: rtl/t48_db_bus_ctrl.sv
// T48 data-bus controller: output latch with OUTL/ORL/ANL, and a MOVX external
// access sequencer (ADDR -> STROBE -> HOLD) with registered pad/strobe outputs.
module t48_db_bus_ctrl #(
  parameter int STROBE_LEN = 2
) (
  input  logic                clk_i,
  input  logic                res_i,
  input  logic                en_clk_i,
  t48_db_bus_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, HOLD} state_e;

  localparam logic [2:0] LAST_CNT = 3'(STROBE_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] rdhold_q, rdhold_d;
  logic [7:0] addr_q, addr_d;
  logic       drive_q, drive_d;
  logic       rd_dir_q, rd_dir_d;
  logic [2:0] cnt_q, cnt_d;

  logic [7:0] db_o_q, db_o_d;
  logic       db_dir_q, db_dir_d;
  logic       ale_q, ale_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       busy_q, busy_d;

  // Neutral 8'hFF keeps this source transparent under the bus AND-mux.
  assign bus.data_o   = bus.read_bus_i ? rdhold_q : 8'hFF;
  assign bus.db_o     = db_o_q;
  assign bus.db_dir_o = db_dir_q;
  assign bus.ale_o    = ale_q;
  assign bus.rd_n_o   = rd_n_q;
  assign bus.wr_n_o   = wr_n_q;
  assign bus.busy_o   = busy_q;

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    rdhold_d = rdhold_q;
    addr_d   = addr_q;
    drive_d  = drive_q;
    rd_dir_d = rd_dir_q;
    cnt_d    = cnt_q;

    if (en_clk_i) begin
      case (state_q)
        IDLE: begin
          if (bus.write_bus_i) begin
            latch_d = bus.data_i;
            drive_d = 1'b1;
          end else if (bus.orl_i) begin
            latch_d = latch_q | bus.data_i;
            drive_d = 1'b1;
          end else if (bus.anl_i) begin
            latch_d = latch_q & bus.data_i;
            drive_d = 1'b1;
          end
          if (bus.movx_rd_i || bus.movx_wr_i) begin
            addr_d   = bus.data_i;
            rd_dir_d = bus.movx_rd_i;
            state_d  = ADDR;
          end
        end
        ADDR: begin
          state_d = STROBE;
          cnt_d   = 3'd0;
        end
        STROBE: begin
          if (cnt_q == LAST_CNT) begin
            state_d = HOLD;
            if (rd_dir_q) rdhold_d = bus.db_i;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        HOLD: begin
          state_d = IDLE;
          if (rd_dir_q) drive_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    // Pin values are decoded from the next state so they leave a flop.
    ale_d    = 1'b0;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    busy_d   = (state_d != IDLE);
    db_o_d   = latch_d;
    db_dir_d = drive_d;
    case (state_d)
      ADDR: begin
        ale_d    = 1'b1;
        db_dir_d = 1'b1;
        db_o_d   = addr_d;
      end
      STROBE: begin
        rd_n_d   = ~rd_dir_d;
        wr_n_d   = rd_dir_d;
        db_dir_d = ~rd_dir_d;
      end
      HOLD:    db_dir_d = ~rd_dir_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q  <= IDLE;
      latch_q  <= 8'hFF;
      rdhold_q <= 8'hFF;
      addr_q   <= 8'h00;
      drive_q  <= 1'b0;
      rd_dir_q <= 1'b0;
      cnt_q    <= 3'd0;
      db_o_q   <= 8'hFF;
      db_dir_q <= 1'b0;
      ale_q    <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      rdhold_q <= rdhold_d;
      addr_q   <= addr_d;
      drive_q  <= drive_d;
      rd_dir_q <= rd_dir_d;
      cnt_q    <= cnt_d;
      db_o_q   <= db_o_d;
      db_dir_q <= db_dir_d;
      ale_q    <= ale_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: doc/t48_db_bus_ctrl.md
T48_DB_BUS_CTRL -- requirements
Module: t48_db_bus_ctrl

Interface
REQ-001 The block SHALL have one parameter, STROBE_LEN, default 2, giving the number of en_clk_i-qualified cycles rd_n_o/wr_n_o stay low (legal 1..7).
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 res_i  input  1  reset, synchronous and active-high.
REQ-004 en_clk_i  input  1  clock enable; state advances only when 1.
REQ-005 data_i  input  8  internal data bus (output of the AND-combining bus mux).
REQ-006 data_o  output  8  this block's source onto the internal bus mux; 8'hFF when not selected.
REQ-007 write_bus_i  input  1  load the output latch from data_i.
REQ-008 read_bus_i  input  1  select the read-hold register onto data_o.
REQ-009 orl_i / anl_i  input  1 each  OR / AND data_i into the output latch.
REQ-010 movx_rd_i / movx_wr_i  input  1 each  start an external read / write cycle; address taken from data_i.
REQ-011 db_i  input  8  external D0-D7 pad input.
REQ-012 db_o  output  8  external D0-D7 pad output value.
REQ-013 db_dir_o  output  1  pad drive enable (1 = drive db_o).
REQ-014 ale_o, rd_n_o, wr_n_o  output  1 each  external address latch enable, read strobe (low active), write strobe (low active).
REQ-015 busy_o  output  1  1 while a MOVX cycle is in progress.

Function
REQ-016 data_o SHALL equal the read-hold register when read_bus_i=1, else 8'hFF, combinationally, so it is neutral under the mux AND.
REQ-017 Output latch SHALL load data_i on write_bus_i, latch|data_i on orl_i, latch&data_i on anl_i, only on en_clk_i=1 cycles with busy_o=0.
REQ-018 Priority among simultaneous latch commands SHALL be write_bus_i > orl_i > anl_i.
REQ-019 FSM states SHALL be IDLE, ADDR, STROBE, HOLD; IDLE is the reset state.
REQ-020 IDLE: movx_rd_i or movx_wr_i with en_clk_i=1 SHALL capture data_i into the address register, record direction, go to ADDR; movx_rd_i wins if both.
REQ-021 ADDR: ale_o=1, db_dir_o=1, db_o=address; next enabled cycle SHALL go to STROBE with strobe counter cleared.
REQ-022 STROBE: rd_n_o=0 (read) or wr_n_o=0 (write) for exactly STROBE_LEN enabled cycles; write drives db_o=output latch with db_dir_o=1; read sets db_dir_o=0.
REQ-023 Read: db_i SHALL be captured into the read-hold register on the last STROBE cycle.
REQ-024 HOLD: strobes deasserted, db_dir_o=0 for read / 1 for write (data hold), one enabled cycle, then IDLE.
REQ-025 busy_o SHALL be 1 in ADDR, STROBE, HOLD; movx requests while busy_o=1 SHALL be ignored (not queued).
REQ-026 Outside MOVX cycles db_o SHALL equal the output latch and db_dir_o SHALL be 1 iff the latch was last written by write_bus_i/orl_i/anl_i since the last read cycle; a completed read cycle SHALL clear this drive flag.
REQ-027 With en_clk_i=0 all registers and outputs SHALL hold.

Reset
REQ-028 res_i=1 SHALL, on the next clock edge regardless of en_clk_i or FSM state, force IDLE, output latch 8'hFF, read-hold 8'hFF, address 8'h00, drive flag 0, counter 0.
REQ-029 During/after reset: ale_o=0, rd_n_o=1, wr_n_o=1, db_dir_o=0, busy_o=0, db_o=8'hFF, data_o=8'hFF; reset mid-cycle SHALL abort the MOVX with no capture.

Verification
REQ-030 Reset, read_bus_i=0 -> data_o=8'hFF, rd_n_o=wr_n_o=1, db_dir_o=0, busy_o=0.
REQ-031 write_bus_i data_i=8'h3C, then orl_i 8'h81, then anl_i 8'h0F -> db_o 8'h3C, 8'hBD, 8'h0D; db_dir_o=1.
REQ-032 movx_rd_i data_i=8'h42, db_i=8'hA5, en_clk_i=1 -> ale_o 1 cycle with db_o=8'h42, rd_n_o low 2 cycles, HOLD, IDLE; read_bus_i=1 -> data_o=8'hA5; total busy 4 cycles.
REQ-033 movx_wr_i addr 8'h10, latch 8'h77, en_clk_i toggling every other cycle -> wr_n_o low for 2 enabled cycles (4 clocks) with db_o=8'h77; write_bus_i during busy ignored.
REQ-034 res_i asserted during STROBE of a read -> next edge IDLE, rd_n_o=1, read-hold 8'hFF, busy_o=0.
REQ-035 write_bus_i and anl_i same cycle, data_i=8'h5A -> latch 8'h5A.
